// File: rtl/prt_frame_drainer.sv
// Drains one Packet Reference Table slot onto a valid/ready egress stream,
// then invalidates the slot so the table can reuse it.
module prt_frame_drainer #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_SLOTS     = 2,
    parameter int MEM_DEPTH     = 1518,
    parameter int START_TIMEOUT = 16,
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int LW = $clog2(MEM_DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN_drain_slot,
    input  logic [SW-1:0]         drain_slot,
    output logic                  RDY_drain_slot,
    output logic                  EN_start_reading_prt_entry,
    output logic [SW-1:0]         start_reading_prt_entry_slot,
    input  logic                  RDY_start_reading_prt_entry,
    output logic                  EN_read_prt_entry,
    input  logic [DATA_WIDTH:0]   read_prt_entry,
    input  logic                  RDY_read_prt_entry,
    output logic                  EN_invalidate_prt_entry,
    output logic [SW-1:0]         invalidate_prt_entry_slot,
    input  logic                  RDY_invalidate_prt_entry,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  tx_last,
    input  logic                  tx_ready,
    output logic                  frame_done,
    output logic [LW-1:0]         frame_len,
    output logic                  drain_error
);

    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_OPEN, S_FETCH, S_WAIT, S_HOLD, S_INVAL
    } state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [LW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]         tout_q, tout_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  tx_last_q, tx_last_d;
    logic [LW-1:0]         frame_len_q, frame_len_d;

    logic fire_start, fire_read, fire_inval, accept, timeout;

    // Strobes depend on the live RDY inputs, so they are decoded from state
    // in the same cycle rather than registered.
    always_comb begin
        accept     = (state_q == S_HOLD) && tx_valid_q && tx_ready;
        fire_start = (state_q == S_OPEN) && RDY_start_reading_prt_entry;
        timeout    = (state_q == S_OPEN) && !RDY_start_reading_prt_entry &&
                     (tout_q == TW'(START_TIMEOUT));
        fire_read  = RDY_read_prt_entry &&
                     ((state_q == S_FETCH) || (accept && !tx_last_q));
        fire_inval = (state_q == S_INVAL) && RDY_invalidate_prt_entry;

        state_d     = state_q;
        slot_d      = slot_q;
        byte_cnt_d  = byte_cnt_q;
        tout_d      = tout_q;
        ovf_d       = ovf_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        tx_last_d   = tx_last_q;
        frame_len_d = frame_len_q;

        unique case (state_q)
            S_IDLE: begin
                if (EN_drain_slot) begin
                    slot_d     = drain_slot;
                    byte_cnt_d = '0;
                    tout_d     = '0;
                    ovf_d      = 1'b0;
                    state_d    = S_OPEN;
                end
            end
            S_OPEN: begin
                if (fire_start) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    frame_len_d = byte_cnt_q;
                    state_d     = S_IDLE;
                end else begin
                    tout_d = tout_q + TW'(1);
                end
            end
            S_FETCH: begin
                if (fire_read) state_d = S_WAIT;
            end
            S_WAIT: begin
                tx_data_d  = read_prt_entry[DATA_WIDTH-1:0];
                tx_valid_d = 1'b1;
                byte_cnt_d = byte_cnt_q + LW'(1);
                if (read_prt_entry[DATA_WIDTH]) begin
                    tx_last_d = 1'b1;
                end else if (byte_cnt_q + LW'(1) == LW'(MEM_DEPTH)) begin
                    // Table holds no more bytes: close the frame and report it.
                    tx_last_d = 1'b1;
                    ovf_d     = 1'b1;
                end else begin
                    tx_last_d = 1'b0;
                end
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (accept) begin
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                    if (tx_last_q)        state_d = S_INVAL;
                    else if (fire_read)   state_d = S_WAIT;
                    else                  state_d = S_FETCH;
                end
            end
            S_INVAL: begin
                if (fire_inval) begin
                    frame_len_d = byte_cnt_q;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            slot_q      <= '0;
            byte_cnt_q  <= '0;
            tout_q      <= '0;
            ovf_q       <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            frame_len_q <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            byte_cnt_q  <= byte_cnt_d;
            tout_q      <= tout_d;
            ovf_q       <= ovf_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
            frame_len_q <= frame_len_d;
        end
    end

    assign RDY_drain_slot               = (state_q == S_IDLE);
    assign EN_start_reading_prt_entry   = fire_start;
    assign EN_read_prt_entry            = fire_read;
    assign EN_invalidate_prt_entry      = fire_inval;
    assign start_reading_prt_entry_slot = slot_q;
    assign invalidate_prt_entry_slot    = slot_q;
    assign tx_data                      = tx_data_q;
    assign tx_valid                     = tx_valid_q;
    assign tx_last                      = tx_last_q;
    assign frame_len                    = frame_len_q;
    assign frame_done                   = fire_inval && !ovf_q;
    assign drain_error                  = (fire_inval && ovf_q) || timeout;

endmodule
